// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: buffers TX words, issues one SPI host transfer at a
// time, and collects replies into an RX FIFO.
// It also has a watchdog with a sticky timeout flag and a wrapping
// count of completed transfers.
// Ports:
//   clk/rst          - clock and synchronous active-high reset
//   wr_*             - TX FIFO push side
//   rd_*             - RX FIFO pop side (first-word fall-through)
//   tx_*, rx_*       - SPI host side
//   busy             - status
//   timeout_err      - sticky watchdog flag, cleared by err_clr
//   txn_count        - completed-transfer count
module spi_txn_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  input  logic        rd_ready,
  output logic [15:0] tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr,
  output logic [7:0]  txn_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nxt;

  logic [15:0]   tx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic [15:0]   rx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic [15:0]   wd_cnt;
  logic tx_push, tx_pop, rx_push, rx_pop, expire;

  // The host raises tx_done together with rx_valid; only rx_valid matters.
  logic unused_tx_done;
  assign unused_tx_done = tx_done;

  assign wr_ready = tx_cnt != FULL;
  assign rd_valid = rx_cnt != '0;
  assign rd_data  = rd_valid ? rx_mem[rx_rp] : '0;
  assign busy     = (state != IDLE) || (tx_cnt != '0);
  assign tx_push  = wr_valid && wr_ready;
  assign rx_pop   = rd_valid && rd_ready;

  // Issue only with an RX slot free, so a reply can never overflow.
  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    expire    = 1'b0;
    unique case (state)
      IDLE: begin
        if ((tx_cnt != '0) && (rx_cnt != FULL)) begin
          state_nxt = ISSUE;
          tx_pop    = 1'b1;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (rx_valid) begin
          rx_push   = 1'b1;
          state_nxt = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_wp       <= '0;
      tx_rp       <= '0;
      tx_cnt      <= '0;
      rx_wp       <= '0;
      rx_rp       <= '0;
      rx_cnt      <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
      txn_count   <= '0;
    end else begin
      state    <= state_nxt;
      tx_start <= tx_pop;
      if (tx_pop) tx_data <= tx_mem[tx_rp];
      if (state == ISSUE) wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 16'd1;
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop) tx_rp <= tx_rp + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop) rx_rp <= rx_rp + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      if (rx_push) txn_count <= txn_count + 8'd1;
      // Expiry beats a same-cycle clear.
      if (expire) timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

  // Storage needs no reset; occupancy counters guard every read.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wr_data;
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end
endmodule
